// File: rtl/data_cache_ctrl_if.sv
// Bus bundle between the packet stream, addr_mgmt and the output scheduler for data_cache_ctrl.
// master = environment side, slave = cache controller side.
interface data_cache_ctrl_if;
  logic [133:0] in_data_ctrl_data;
  logic         in_data_ctrl_data_wr;
  logic         out_data_ctrl_ready;
  logic [10:0]  in_waddr;
  logic         in_waddr_wr;
  logic         out_wr_valid;
  logic         out_wr_valid_wr;
  logic [10:0]  in_raddr;
  logic         in_raddr_wr;
  logic [133:0] out_pkt_data;
  logic         out_pkt_data_wr;
  logic         out_rd_valid;

  modport master (
    output in_data_ctrl_data, in_data_ctrl_data_wr, in_waddr, in_waddr_wr,
           in_raddr, in_raddr_wr,
    input  out_data_ctrl_ready, out_wr_valid, out_wr_valid_wr,
           out_pkt_data, out_pkt_data_wr, out_rd_valid
  );

  modport slave (
    input  in_data_ctrl_data, in_data_ctrl_data_wr, in_waddr, in_waddr_wr,
           in_raddr, in_raddr_wr,
    output out_data_ctrl_ready, out_wr_valid, out_wr_valid_wr,
           out_pkt_data, out_pkt_data_wr, out_rd_valid
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Packet data cache: stores 134-bit packet words into 16 x 128-word slots of a 2048x134 RAM
// and streams a stored packet back out on request, reporting completion for slot recycling.
module data_cache_ctrl #(
  parameter string PLATFORM = "xilinx"
) (
  input logic         clk,
  input logic         rst_n,
  data_cache_ctrl_if.slave bus
);

  localparam logic [1:0] CODE_HEAD = 2'b01;
  localparam logic [1:0] CODE_TAIL = 2'b10;

  typedef enum logic [2:0] {W_WAIT_ADDR, W_WAIT_HEAD, W_BODY, W_FULL, W_DISCARD} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE} rstate_e;

  wstate_e      wstate_q, wstate_d;
  logic [10:0]  wbase_q, wbase_d;
  logic [6:0]   woff_q, woff_d;
  logic         wr_valid_q, wr_valid_d;
  logic         wr_valid_wr_q, wr_valid_wr_d;
  logic         ram_we;
  logic [10:0]  ram_waddr;
  logic         in_head, in_tail;

  rstate_e      rstate_q, rstate_d;
  logic [10:0]  rbase_q, rbase_d;
  logic [6:0]   roff_q, roff_d;
  logic         rstop_q, rstop_d;
  logic         rvalid_q, rvalid_d;
  logic         rlast_q, rlast_d;
  logic         rd_en;
  logic [10:0]  ram_raddr;
  logic [133:0] ram_rdata_q;
  logic         ret_tail;
  logic [133:0] pkt_data_q, pkt_data_d;
  logic         pkt_data_wr_q, pkt_data_wr_d;
  logic         rd_valid_q, rd_valid_d;

  assign in_head = bus.in_data_ctrl_data[133:132] == CODE_HEAD;
  assign in_tail = bus.in_data_ctrl_data[133:132] == CODE_TAIL;

  always_comb begin
    wstate_d      = wstate_q;
    wbase_d       = wbase_q;
    woff_d        = woff_q;
    wr_valid_d    = 1'b0;
    wr_valid_wr_d = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = wbase_q | {4'd0, woff_q};
    case (wstate_q)
      W_WAIT_ADDR: begin
        if (bus.in_waddr_wr) begin
          wbase_d  = bus.in_waddr;
          woff_d   = '0;
          wstate_d = W_WAIT_HEAD;
        end
      end
      W_WAIT_HEAD: begin
        if (bus.in_data_ctrl_data_wr && in_head) begin
          ram_we   = 1'b1;
          woff_d   = 7'd1;
          wstate_d = W_BODY;
        end
      end
      W_BODY: begin
        if (bus.in_data_ctrl_data_wr) begin
          if (in_head) begin
            wr_valid_wr_d = 1'b1;
            wstate_d      = W_DISCARD;
          end else begin
            ram_we = 1'b1;
            woff_d = woff_q + 7'd1;
            if (in_tail) begin
              wr_valid_wr_d = 1'b1;
              wr_valid_d    = 1'b1;
              wstate_d      = W_WAIT_ADDR;
            end else if (woff_q == 7'd127) begin
              wstate_d = W_FULL;
            end
          end
        end
      end
      // Slot is full: whatever arrives next overflows and is dropped.
      W_FULL: begin
        if (bus.in_data_ctrl_data_wr) begin
          wr_valid_wr_d = 1'b1;
          wstate_d      = in_tail ? W_WAIT_ADDR : W_DISCARD;
        end
      end
      W_DISCARD: begin
        if (bus.in_data_ctrl_data_wr && in_tail) wstate_d = W_WAIT_ADDR;
      end
      default: wstate_d = W_WAIT_ADDR;
    endcase
  end

  // Tail is checked on the word returning from RAM this cycle, so no read is issued past it.
  assign ret_tail = rvalid_q && (ram_rdata_q[133:132] == CODE_TAIL);

  always_comb begin
    rstate_d      = rstate_q;
    rbase_d       = rbase_q;
    roff_d        = roff_q;
    rstop_d       = rstop_q;
    rd_en         = 1'b0;
    rlast_d       = 1'b0;
    rd_valid_d    = 1'b0;
    ram_raddr     = rbase_q | {4'd0, roff_q};
    pkt_data_wr_d = rvalid_q;
    pkt_data_d    = rvalid_q ? ram_rdata_q : pkt_data_q;
    case (rstate_q)
      R_IDLE: begin
        if (bus.in_raddr_wr) begin
          rbase_d  = bus.in_raddr;
          roff_d   = '0;
          rstop_d  = 1'b0;
          rstate_d = R_READ;
        end
      end
      R_READ: begin
        if (!rstop_q && !ret_tail) begin
          rd_en  = 1'b1;
          roff_d = roff_q + 7'd1;
          if (roff_q == 7'd127) begin
            rstop_d = 1'b1;
            rlast_d = 1'b1;
          end
        end
        if (ret_tail || (rvalid_q && rlast_q)) rstate_d = R_DONE;
      end
      R_DONE: begin
        rd_valid_d = 1'b1;
        rstate_d   = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign rvalid_d = rd_en;

  if (PLATFORM == "xilinx") begin : g_ram
    (* ram_style = "block" *) logic [133:0] mem [0:2047];
    always_ff @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= bus.in_data_ctrl_data;
      if (rd_en)  ram_rdata_q    <= mem[ram_raddr];
    end
  end else begin : g_ram
    logic [133:0] mem [0:2047];
    always_ff @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= bus.in_data_ctrl_data;
      if (rd_en)  ram_rdata_q    <= mem[ram_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q      <= W_WAIT_ADDR;
      wbase_q       <= '0;
      woff_q        <= '0;
      wr_valid_q    <= 1'b0;
      wr_valid_wr_q <= 1'b0;
      rstate_q      <= R_IDLE;
      rbase_q       <= '0;
      roff_q        <= '0;
      rstop_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      pkt_data_q    <= '0;
      pkt_data_wr_q <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      wstate_q      <= wstate_d;
      wbase_q       <= wbase_d;
      woff_q        <= woff_d;
      wr_valid_q    <= wr_valid_d;
      wr_valid_wr_q <= wr_valid_wr_d;
      rstate_q      <= rstate_d;
      rbase_q       <= rbase_d;
      roff_q        <= roff_d;
      rstop_q       <= rstop_d;
      rvalid_q      <= rvalid_d;
      rlast_q       <= rlast_d;
      pkt_data_q    <= pkt_data_d;
      pkt_data_wr_q <= pkt_data_wr_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign bus.out_data_ctrl_ready = (wstate_q != W_WAIT_ADDR);
  assign bus.out_wr_valid        = wr_valid_q;
  assign bus.out_wr_valid_wr     = wr_valid_wr_q;
  assign bus.out_pkt_data        = pkt_data_q;
  assign bus.out_pkt_data_wr     = pkt_data_wr_q;
  assign bus.out_rd_valid        = rd_valid_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: table of packets written then read back,
// plus concurrent, same-address collision and mid-transfer reset sequences.
module tb_data_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_ctrl_if bus();

  data_cache_ctrl #(.PLATFORM("xilinx")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0] model [2048];
  logic [133:0] exp_rd_q[$];
  bit           exp_wr_q[$];
  int wr_pulses = 0, wr_pulse_cyc = 0;
  int rd_beats = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  int rd_done = 0, rd_done_cyc = 0;

  typedef struct {
    logic [10:0] base;
    int          n;
    int          head2;
    logic [1:0]  midc;
    int          exp_stored;
    bit          exp_valid;
    int          trig;
    int          exp_beats;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got a strobe at cycle %0d, required none", name, cyc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_int({tag, "_ready"}, int'(bus.out_data_ctrl_ready), 0);
    check_int({tag, "_wr_valid"}, int'(bus.out_wr_valid), 0);
    check_int({tag, "_wr_valid_wr"}, int'(bus.out_wr_valid_wr), 0);
    check({tag, "_pkt_data"}, bus.out_pkt_data, '0);
    check_int({tag, "_pkt_data_wr"}, int'(bus.out_pkt_data_wr), 0);
    check_int({tag, "_rd_valid"}, int'(bus.out_rd_valid), 0);
  endtask

  always @(negedge clk) begin
    if (bus.out_wr_valid_wr) begin
      wr_pulses++;
      wr_pulse_cyc = cyc;
      if (exp_wr_q.size() == 0) report_unexpected("wr_valid_wr_unexpected");
      else check_int("wr_valid", int'(bus.out_wr_valid), int'(exp_wr_q.pop_front()));
    end
    if (bus.out_pkt_data_wr) begin
      if (rd_beats == 0) first_beat_cyc = cyc;
      rd_beats++;
      last_beat_cyc = cyc;
      if (exp_rd_q.size() == 0) report_unexpected("pkt_data_wr_unexpected");
      else check("pkt_data", bus.out_pkt_data, exp_rd_q.pop_front());
    end
    if (bus.out_rd_valid) begin
      rd_done++;
      rd_done_cyc = cyc;
    end
  end

  task automatic write_pkt(input logic [10:0] base, input int n, input int head2,
                           input logic [1:0] midc, input int exp_stored,
                           input bit exp_valid, input int trig);
    int pulses0, trig_cyc, t;
    logic [133:0] w;
    logic [1:0] code;
    bus.in_waddr    = base;
    bus.in_waddr_wr = 1'b1;
    tick();
    bus.in_waddr_wr = 1'b0;
    t = 0;
    while (!bus.out_data_ctrl_ready && t < 10) begin
      tick();
      t++;
    end
    check_int("ready_before_head", int'(bus.out_data_ctrl_ready), 1);
    pulses0  = wr_pulses;
    trig_cyc = 0;
    exp_wr_q.push_back(exp_valid);
    for (int i = 0; i < n; i++) begin
      code = (i == 0 || i == head2) ? 2'b01 : (i == n - 1) ? 2'b10 : midc;
      w = {code, base, 8'(i), $urandom(), $urandom(), $urandom(), 17'($urandom())};
      if (i < exp_stored) model[base | 11'(i)] = w;
      if (i == trig) trig_cyc = cyc;
      bus.in_data_ctrl_data    = w;
      bus.in_data_ctrl_data_wr = 1'b1;
      tick();
    end
    bus.in_data_ctrl_data_wr = 1'b0;
    tick();
    check_int("wr_pulse_count", wr_pulses - pulses0, 1);
    check_int("wr_pulse_cycle", wr_pulse_cyc, trig_cyc + 1);
    check_int("ready_after_pkt", int'(bus.out_data_ctrl_ready), 0);
  endtask

  task automatic read_pkt(input logic [10:0] base, input int exp_beats);
    int k, t, d0;
    for (int i = 0; i < 128; i++) begin
      exp_rd_q.push_back(model[base | 11'(i)]);
      if (model[base | 11'(i)][133:132] == 2'b10) break;
    end
    rd_beats        = 0;
    d0              = rd_done;
    bus.in_raddr    = base;
    bus.in_raddr_wr = 1'b1;
    k = cyc;
    tick();
    bus.in_raddr_wr = 1'b0;
    t = 0;
    while (rd_done == d0 && t < 300) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check_int("rd_valid_count", rd_done - d0, 1);
    check_int("rd_beats", rd_beats, exp_beats);
    check_int("first_beat_cycle", first_beat_cyc, k + 3);
    check_int("last_beat_cycle", last_beat_cyc, k + 2 + exp_beats);
    check_int("rd_valid_cycle", rd_done_cyc, k + 3 + exp_beats);
    check_int("rd_expected_left", exp_rd_q.size(), 0);
    exp_rd_q.delete();
  endtask

  initial begin
    int d0, w0;
    bus.in_data_ctrl_data    = '0;
    bus.in_data_ctrl_data_wr = 1'b0;
    bus.in_waddr             = '0;
    bus.in_waddr_wr          = 1'b0;
    bus.in_raddr             = '0;
    bus.in_raddr_wr          = 1'b0;

    // base, n, head2, midc, exp_stored, exp_valid, trig, exp_beats
    vecs[0] = '{11'h080,   4, -1, 2'b11,   4, 1'b1,   3,   4};
    vecs[1] = '{11'h180,   6, -1, 2'b00,   6, 1'b1,   5,   6};
    vecs[2] = '{11'h100, 130, -1, 2'b11, 128, 1'b0, 128, 128};
    vecs[3] = '{11'h200,   5,  2, 2'b11,   2, 1'b0,   2,   0};
    vecs[4] = '{11'h280,   2, -1, 2'b11,   2, 1'b1,   1,   2};
    vecs[5] = '{11'h380, 128, -1, 2'b11, 128, 1'b1, 127, 128};
    vecs[6] = '{11'h400, 129, -1, 2'b11, 128, 1'b0, 128, 128};

    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++)
      write_pkt(vecs[v].base, vecs[v].n, vecs[v].head2, vecs[v].midc,
                vecs[v].exp_stored, vecs[v].exp_valid, vecs[v].trig);
    for (int v = 0; v < 7; v++)
      if (vecs[v].exp_beats > 0) read_pkt(vecs[v].base, vecs[v].exp_beats);

    // Write slot 2 while reading slot 5.
    fork
      write_pkt(11'h100, 5, -1, 2'b11, 5, 1'b1, 4);
      read_pkt(11'h280, 2);
    join
    read_pkt(11'h100, 5);

    // Same-address collision: each read offset meets the write of that offset; old data returns.
    fork
      write_pkt(11'h080, 6, -1, 2'b11, 6, 1'b1, 5);
      read_pkt(11'h080, 4);
    join
    read_pkt(11'h080, 6);

    // Reset in the middle of a read and of a write.
    rd_beats = 0;
    d0 = rd_done;
    w0 = wr_pulses;
    for (int i = 0; i < 128; i++) exp_rd_q.push_back(model[11'h380 | 11'(i)]);
    bus.in_raddr    = 11'h380;
    bus.in_raddr_wr = 1'b1;
    bus.in_waddr    = 11'h500;
    bus.in_waddr_wr = 1'b1;
    tick();
    bus.in_raddr_wr = 1'b0;
    bus.in_waddr_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data_ctrl_data    = {(i == 0) ? 2'b01 : 2'b11, 100'(i), 32'($urandom())};
      bus.in_data_ctrl_data_wr = 1'b1;
      tick();
    end
    bus.in_data_ctrl_data_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    exp_rd_q.delete();
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    repeat (20) tick();
    check_int("beats_before_reset", rd_beats, 3);
    check_int("no_wr_pulse_after_reset", wr_pulses - w0, 0);
    check_int("no_rd_valid_after_reset", rd_done - d0, 0);
    check_int("ready_idle_after_reset", int'(bus.out_data_ctrl_ready), 0);
    write_pkt(11'h500, 3, -1, 2'b11, 3, 1'b1, 2);
    read_pkt(11'h500, 3);

    check_int("wr_expected_left", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Packet data cache controller sitting between the switch input stream and the output scheduler, directly beside `addr_mgmt`. It stores each incoming 134-bit packet into a 2048×134 on-chip RAM. The RAM is divided into 16 slots of 128 words, and the write base address for each slot comes from `addr_mgmt`. On a read base address from `addr_mgmt`, the block streams the stored packet out and reports completion so the slot ID can be recycled.

## Interface
- `PLATFORM`, default `"xilinx"`: selects the RAM implementation. Behaviour is identical on every platform.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data_ctrl_data`  in  134  packet word. Bits [133:132]: 01 = head, 11 = middle, 10 = tail; 00 is treated as middle.
- `in_data_ctrl_data_wr`  in  1  word strobe.
- `out_data_ctrl_ready`  out  1  upstream may start a head word only while this is 1.
- `in_waddr`  in  11  write slot base address from `addr_mgmt` (low 7 bits are 0).
- `in_waddr_wr`  in  1  one-cycle strobe for `in_waddr`.
- `out_wr_valid`  out  1  1 = packet stored OK; 0 = packet dropped.
- `out_wr_valid_wr`  out  1  one-cycle strobe for `out_wr_valid`.
- `in_raddr`  in  11  read slot base address.
- `in_raddr_wr`  in  1  one-cycle strobe for `in_raddr`.
- `out_pkt_data`  out  134  read-out packet word.
- `out_pkt_data_wr`  out  1  strobe for `out_pkt_data`.
- `out_rd_valid`  out  1  one-cycle pulse when a read completes (drives `in_ram2addr_valid`).

## Operation
- RAM: simple dual-port, 2048×134. Write is registered and takes effect at the clock edge. Read has 1-cycle latency. If the same address is read and written in one cycle, the read returns the old data.
- Write FSM (`wbase` 11b, `woff` 7b):
  - W_WAIT_ADDR: on `in_waddr_wr`, latch `wbase`, clear `woff`, go to W_WAIT_HEAD. Data words arriving in this state are ignored.
  - W_WAIT_HEAD: ready=1.
    - Head with wr: write at `wbase`, set `woff`=1, go to W_BODY.
    - Non-head words: ignored.
  - W_BODY: each wr word is written at `wbase | woff`, then `woff`++.
    - Tail: write it, pulse valid_wr with valid=1 next cycle, go to W_WAIT_ADDR.
    - A non-tail word arriving with `woff`=127 is written. The next wr word is not written; instead pulse valid=0 and go to W_DISCARD, unless that word is a tail, in which case go to W_WAIT_ADDR.
    - A head while in W_BODY: not written; pulse valid=0, go to W_DISCARD.
  - W_DISCARD: ready=1. Drop words until a tail arrives, then go to W_WAIT_ADDR.
- `out_data_ctrl_ready` = 1 in W_WAIT_HEAD, W_BODY and W_DISCARD. It is never withdrawn mid-packet.
- Read FSM (`rbase`, `roff` 7b):
  - R_IDLE: on `in_raddr_wr`, latch `rbase`, clear `roff`, go to R_READ.
  - R_READ: issue a RAM read at `rbase | roff` each cycle and increment `roff`.
    - Returned data is registered onto `out_pkt_data` with `out_pkt_data_wr`=1.
    - When a returned word carries the tail code, or after 128 words, stop issuing reads. At most one extra read is issued after the tail; its data is discarded and never emitted.
    - Go to R_DONE.
  - R_DONE: pulse `out_rd_valid` for one cycle, go to R_IDLE.
- `in_raddr_wr` outside R_IDLE is ignored. `in_waddr_wr` outside W_WAIT_ADDR is ignored.
- The read and write FSMs run independently and concurrently on different slots.

## Timing
- Reset (`rst_n`=0 at an edge): the write FSM goes to W_WAIT_ADDR and the read FSM to R_IDLE. All outputs are 0: ready, valid, valid_wr, pkt_data, pkt_data_wr, rd_valid.
- RAM contents are not cleared. A reset mid-packet abandons that packet silently: no valid_wr pulse.
- Write latency: a word with wr at cycle N is in the RAM after edge N. `out_wr_valid_wr` is high in cycle N+1 for a tail (or error) at N.
- Read latency: with `in_raddr_wr` at cycle N, the first read is issued at N+1 and `out_pkt_data_wr` rises at N+3. Words are emitted back-to-back.
- `out_rd_valid` is high the cycle after the last `out_pkt_data_wr`.
- Address arithmetic: offsets are OR-ed into the low 7 bits. No carry into the slot ID and no wrap into a neighbouring slot.

## Test plan
- Waddr 0x080, then a 4-word packet (01, 11, 11, 10) → RAM[0x080..0x083] hold the words; valid_wr=1 with valid=1 one cycle after the tail; ready=0 afterwards.
- Raddr 0x080 after the above → 4 consecutive `out_pkt_data_wr` beats starting 3 cycles after raddr_wr with identical data; `out_rd_valid` the cycle after the 4th beat; no 5th beat.
- 130-word packet into slot 0x100 → words 0..127 stored; valid_wr with valid=0 at word 128; word 129 (tail) dropped; FSM back in W_WAIT_ADDR; RAM[0x180] untouched.
- Head, middle, head, middle, tail → valid=0 at the 2nd head; remaining words dropped until the tail; exactly one valid_wr pulse.
- Concurrent write to slot 2 and read of slot 5 → both complete with correct data; read-first on a same-address collision.
- `rst_n` low for 1 cycle mid-write and mid-read → all outputs 0 the next cycle; no valid_wr or `out_rd_valid` pulse for either aborted transfer; a new waddr is accepted afterwards.
